// File: rtl/noc_router_pkg.sv
// Shared router definitions: arbiter state encoding and the round-robin
// one-hot search that the router arbiters have in common.
package noc_router_pkg;

   // Widest requester vector the shared round-robin helper handles.
   localparam int unsigned RR_MAX_PORTS = 16;

   typedef enum logic [0:0] {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;

   // Round-robin pick: first set bit of req strictly after the one-hot prev,
   // searching upward and wrapping. Narrower callers zero-pad req and prev;
   // the padding never requests, so the wrap lands on bit 0 as expected.
   // A zero req yields a zero grant.
   function automatic logic [RR_MAX_PORTS-1:0] rr_next(
      input logic [RR_MAX_PORTS-1:0] req,
      input logic [RR_MAX_PORTS-1:0] prev
   );
      logic [2*RR_MAX_PORTS-1:0] dbl_req;
      logic [2*RR_MAX_PORTS-1:0] dbl_base;
      logic [2*RR_MAX_PORTS-1:0] dbl_grant;
      dbl_req   = {req, req};
      dbl_base  = {{RR_MAX_PORTS{1'b0}}, prev[RR_MAX_PORTS-2:0], prev[RR_MAX_PORTS-1]};
      dbl_grant = dbl_req & ~(dbl_req - dbl_base);
      return dbl_grant[RR_MAX_PORTS-1:0] | dbl_grant[2*RR_MAX_PORTS-1:RR_MAX_PORTS];
   endfunction

endpackage

// File: rtl/noc_router_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant for the first requester
// after prev_grant, found with a doubled-vector priority search.
module noc_router_rr_arbiter
   import noc_router_pkg::*;
#(
   parameter int unsigned INPUTS = 5
) (
   input  logic [INPUTS-1:0] req,
   input  logic [INPUTS-1:0] prev_grant,
   output logic [INPUTS-1:0] grant
);

   logic [2*INPUTS-1:0] dbl_req_s;
   logic [2*INPUTS-1:0] dbl_base_s;
   logic [2*INPUTS-1:0] dbl_grant_s;

   // Rotate prev_grant up by one to get the search start, then isolate the
   // first request at or above it in the doubled vector and fold it back.
   always_comb begin
      dbl_req_s  = {req, req};
      dbl_base_s = '0;
      for (int i = 0; i < int'(INPUTS); i++) begin
         dbl_base_s[(i + 1) % int'(INPUTS)] = prev_grant[i];
      end
      dbl_grant_s = dbl_req_s & ~(dbl_req_s - dbl_base_s);
      grant       = dbl_grant_s[INPUTS-1:0] | dbl_grant_s[2*INPUTS-1:INPUTS];
   end

endmodule

// File: rtl/noc_router_output_arbiter.sv
// Wormhole-aware round-robin arbiter for one router output port. A grant is
// held from header to last so flits of different packets never interleave.
// The datapath is purely combinational: zero latency, no flit storage.
module noc_router_output_arbiter
   import noc_router_pkg::*;
#(
   parameter int unsigned FLIT_WIDTH = 32,
   parameter int unsigned INPUTS     = 5
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [INPUTS*FLIT_WIDTH-1:0] in_flit,
   input  logic [INPUTS-1:0]            in_last,
   input  logic [INPUTS-1:0]            in_valid,
   output logic [INPUTS-1:0]            in_ready,
   output logic [FLIT_WIDTH-1:0]        out_flit,
   output logic                         out_last,
   output logic                         out_valid,
   input  logic                         out_ready
);

   // Pointer starts on the top input so input 0 wins the first arbitration.
   localparam logic [INPUTS-1:0] GRANT_ONE = INPUTS'(1'b1);
   localparam logic [INPUTS-1:0] PREV_RST  = GRANT_ONE << (INPUTS - 1);

   arb_state_e            state_r;
   arb_state_e            state_nxt_s;
   logic [INPUTS-1:0]     lock_grant_r;
   logic [INPUTS-1:0]     lock_grant_nxt_s;
   logic [INPUTS-1:0]     prev_grant_r;
   logic [INPUTS-1:0]     prev_grant_nxt_s;
   logic [INPUTS-1:0]     rr_grant_s;
   logic [INPUTS-1:0]     grant_s;
   logic [FLIT_WIDTH-1:0] flit_mux_s;
   logic                  last_mux_s;
   logic                  valid_mux_s;
   logic                  worm_done_s;

   noc_router_rr_arbiter #(
      .INPUTS (INPUTS)
   ) u_rr_arbiter (
      .req        (in_valid),
      .prev_grant (prev_grant_r),
      .grant      (rr_grant_s)
   );

   // Active grant: live round-robin result when idle, held grant mid-worm,
   // nothing while reset is asserted so no handshake can occur.
   always_comb begin
      grant_s = '0;
      if (rst) begin
         grant_s = '0;
      end else begin
         case (state_r)
            ARB_IDLE:   grant_s = rr_grant_s;
            ARB_LOCKED: grant_s = lock_grant_r;
            default:    grant_s = '0;
         endcase
      end
   end

   // One-hot AND-OR mux of the granted input's flit, last and valid.
   always_comb begin
      flit_mux_s = '0;
      for (int i = 0; i < int'(INPUTS); i++) begin
         flit_mux_s = flit_mux_s | (in_flit[i*FLIT_WIDTH +: FLIT_WIDTH] & {FLIT_WIDTH{grant_s[i]}});
      end
      last_mux_s  = |(grant_s & in_last);
      valid_mux_s = |(grant_s & in_valid);
      worm_done_s = valid_mux_s & out_ready & last_mux_s;
   end

   assign out_flit  = flit_mux_s;
   assign out_last  = last_mux_s;
   assign out_valid = valid_mux_s;
   assign in_ready  = grant_s & {INPUTS{out_ready}};

   // Lock on any grant that does not finish its worm this cycle; the pointer
   // moves only when a worm completes, so a stalled request never advances it.
   always_comb begin
      state_nxt_s      = state_r;
      lock_grant_nxt_s = lock_grant_r;
      prev_grant_nxt_s = prev_grant_r;
      case (state_r)
         ARB_IDLE: begin
            if (worm_done_s) begin
               prev_grant_nxt_s = grant_s;
            end else if (grant_s != '0) begin
               state_nxt_s      = ARB_LOCKED;
               lock_grant_nxt_s = grant_s;
            end else begin
               state_nxt_s = ARB_IDLE;
            end
         end
         ARB_LOCKED: begin
            if (worm_done_s) begin
               state_nxt_s      = ARB_IDLE;
               prev_grant_nxt_s = lock_grant_r;
            end else begin
               state_nxt_s = ARB_LOCKED;
            end
         end
         default: begin
            state_nxt_s = ARB_IDLE;
         end
      endcase
   end

   // State, lock and pointer registers; reset drops any lock in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ARB_IDLE;
         lock_grant_r <= '0;
         prev_grant_r <= PREV_RST;
      end else begin
         state_r      <= state_nxt_s;
         lock_grant_r <= lock_grant_nxt_s;
         prev_grant_r <= prev_grant_nxt_s;
      end
   end

endmodule

// File: tb/tb_noc_router_output_arbiter.sv
// Directed bench for the wormhole output arbiter: a 5-input instance for
// arbitration and locking, a 1-input instance for the pass-through stream.
module tb_noc_router_output_arbiter;

   localparam int FW = 32;
   localparam int NI = 5;

   logic            clk = 1'b0;
   logic            rst;
   logic [NI*FW-1:0] in_flit;
   logic [NI-1:0]   in_last;
   logic [NI-1:0]   in_valid;
   logic [NI-1:0]   in_ready;
   logic [FW-1:0]   out_flit;
   logic            out_last;
   logic            out_valid;
   logic            out_ready;

   logic [FW-1:0]   s_in_flit;
   logic            s_in_last;
   logic            s_in_valid;
   logic            s_in_ready;
   logic [FW-1:0]   s_out_flit;
   logic            s_out_last;
   logic            s_out_valid;
   logic            s_out_ready;

   int n_checks = 0;
   int n_fail   = 0;

   logic [FW-1:0] stream_flit [500];
   logic          stream_last [500];
   int            k;

   always #5 clk = ~clk;

   noc_router_output_arbiter #(.FLIT_WIDTH(FW), .INPUTS(NI)) dut (
      .clk(clk), .rst(rst), .in_flit(in_flit), .in_last(in_last),
      .in_valid(in_valid), .in_ready(in_ready), .out_flit(out_flit),
      .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready)
   );

   noc_router_output_arbiter #(.FLIT_WIDTH(FW), .INPUTS(1)) dut1 (
      .clk(clk), .rst(rst), .in_flit(s_in_flit), .in_last(s_in_last),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .out_flit(s_out_flit),
      .out_last(s_out_last), .out_valid(s_out_valid), .out_ready(s_out_ready)
   );

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input int i, input logic v, input logic l, input logic [FW-1:0] f);
      in_valid[i]          = v;
      in_last[i]           = l;
      in_flit[i*FW +: FW]  = f;
   endtask

   task automatic expect_out(input string tag, input logic [NI-1:0] rdy, input logic vld,
                             input logic [FW-1:0] f, input logic l);
      #1;
      check_eq({tag, "_ready"}, 64'(in_ready), 64'(rdy));
      check_eq({tag, "_valid"}, 64'(out_valid), 64'(vld));
      check_eq({tag, "_flit"}, 64'(out_flit), 64'(f));
      check_eq({tag, "_last"}, 64'(out_last), 64'(l));
   endtask

   initial begin
      rst         = 1'b1;
      in_flit     = '0;
      in_last     = '0;
      in_valid    = '0;
      out_ready   = 1'b1;
      s_in_flit   = '0;
      s_in_last   = 1'b0;
      s_in_valid  = 1'b0;
      s_out_ready = 1'b0;

      // Reset with every input requesting: nothing may be granted.
      for (int i = 0; i < NI; i++) set_in(i, 1'b1, 1'b1, 32'hA0 + 32'(i));
      step();
      step();
      expect_out("reset_hold", 5'b00000, 1'b0, 32'h0, 1'b0);

      // Single-flit packets from all inputs: grants 0,1,2,3,4,0 with no bubble.
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         expect_out("rr_cycle", 5'(5'b00001 << (c % NI)), 1'b1, 32'hA0 + 32'(c % NI), 1'b1);
         step();
      end
      in_valid = '0;
      step();

      // Input 2 sends a 4-flit worm while input 3 requests from its second flit.
      set_in(2, 1'b1, 1'b0, 32'h20);
      expect_out("worm_f0", 5'b00100, 1'b1, 32'h20, 1'b0);
      step();
      set_in(2, 1'b1, 1'b0, 32'h21);
      set_in(3, 1'b1, 1'b1, 32'h30);
      expect_out("worm_f1", 5'b00100, 1'b1, 32'h21, 1'b0);
      step();
      set_in(2, 1'b1, 1'b0, 32'h22);
      expect_out("worm_f2", 5'b00100, 1'b1, 32'h22, 1'b0);
      step();
      set_in(2, 1'b1, 1'b1, 32'h23);
      expect_out("worm_f3", 5'b00100, 1'b1, 32'h23, 1'b1);
      step();
      set_in(2, 1'b0, 1'b0, 32'h0);
      expect_out("worm_next", 5'b01000, 1'b1, 32'h30, 1'b1);
      step();
      set_in(3, 1'b0, 1'b0, 32'h0);

      // Stalled header on input 1; input 0 joins at cycle 2 but must wait.
      out_ready = 1'b0;
      set_in(1, 1'b1, 1'b1, 32'h11);
      for (int c = 0; c < 5; c++) begin
         if (c == 2) set_in(0, 1'b1, 1'b1, 32'h01);
         expect_out("stall_hold", 5'b00000, 1'b1, 32'h11, 1'b1);
         step();
      end
      out_ready = 1'b1;
      expect_out("stall_release", 5'b00010, 1'b1, 32'h11, 1'b1);
      step();
      set_in(1, 1'b0, 1'b0, 32'h0);
      expect_out("stall_next", 5'b00001, 1'b1, 32'h01, 1'b1);
      step();
      set_in(0, 1'b0, 1'b0, 32'h0);

      // Input 4 worm with a 3-cycle valid gap; input 0 requests during the gap.
      set_in(4, 1'b1, 1'b0, 32'h41);
      expect_out("bubble_f0", 5'b10000, 1'b1, 32'h41, 1'b0);
      step();
      set_in(4, 1'b1, 1'b0, 32'h42);
      expect_out("bubble_f1", 5'b10000, 1'b1, 32'h42, 1'b0);
      step();
      set_in(4, 1'b0, 1'b0, 32'h0);
      set_in(0, 1'b1, 1'b1, 32'h0F);
      for (int c = 0; c < 3; c++) begin
         expect_out("bubble_gap", 5'b10000, 1'b0, 32'h0, 1'b0);
         step();
      end
      set_in(4, 1'b1, 1'b0, 32'h43);
      expect_out("bubble_f2", 5'b10000, 1'b1, 32'h43, 1'b0);
      step();
      set_in(4, 1'b1, 1'b1, 32'h44);
      expect_out("bubble_f3", 5'b10000, 1'b1, 32'h44, 1'b1);
      step();
      set_in(4, 1'b0, 1'b0, 32'h0);
      expect_out("bubble_next", 5'b00001, 1'b1, 32'h0F, 1'b1);
      step();
      set_in(0, 1'b0, 1'b0, 32'h0);

      // Reset in the middle of input 3's worm drops the lock and the pointer.
      set_in(3, 1'b1, 1'b0, 32'h35);
      expect_out("rstworm_f0", 5'b01000, 1'b1, 32'h35, 1'b0);
      step();
      set_in(3, 1'b1, 1'b0, 32'h36);
      expect_out("rstworm_f1", 5'b01000, 1'b1, 32'h36, 1'b0);
      step();
      rst = 1'b1;
      expect_out("rstworm_in_rst", 5'b00000, 1'b0, 32'h0, 1'b0);
      step();
      expect_out("rstworm_after", 5'b00000, 1'b0, 32'h0, 1'b0);
      set_in(0, 1'b1, 1'b1, 32'h02);
      set_in(3, 1'b1, 1'b1, 32'h37);
      rst = 1'b0;
      expect_out("rstworm_win0", 5'b00001, 1'b1, 32'h02, 1'b1);
      step();
      set_in(0, 1'b0, 1'b0, 32'h0);
      expect_out("rstworm_then3", 5'b01000, 1'b1, 32'h37, 1'b1);
      step();
      set_in(3, 1'b0, 1'b0, 32'h0);

      // Single-input pass-through: continuous random stream, random out_ready.
      for (int i = 0; i < 500; i++) begin
         stream_flit[i] = $urandom;
         stream_last[i] = ($urandom_range(0, 3) == 0);
      end
      k = 0;
      s_in_valid = 1'b1;
      for (int c = 0; c < 5000 && k < 500; c++) begin
         s_in_flit   = stream_flit[k];
         s_in_last   = stream_last[k];
         s_out_ready = 1'($urandom_range(0, 1));
         #1;
         check_eq("pass_ready", 64'(s_in_ready), 64'(s_out_ready));
         check_eq("pass_valid", 64'(s_out_valid), 64'(1'b1));
         check_eq("pass_flit", 64'(s_out_flit), 64'(stream_flit[k]));
         check_eq("pass_last", 64'(s_out_last), 64'(stream_last[k]));
         if (s_out_ready) k++;
         step();
      end
      s_in_valid = 1'b0;
      check_eq("pass_count", 64'(k), 64'(500));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
